// File: rtl/sram_req_arbiter_pkg.sv
// sram_req_arbiter_pkg: requester ids and default outstanding depth shared by the arbiter and its order FIFO.
package sram_req_arbiter_pkg;
    typedef logic arb_id_t;
    localparam arb_id_t ARB_ID_INST  = 1'b0;
    localparam arb_id_t ARB_ID_DATA  = 1'b1;
    localparam int      ARB_OT_DEPTH = 4;
endpackage

// File: rtl/arb_order_fifo.sv
// arb_order_fifo: in-order FIFO of granted requester ids, one entry per outstanding request.
module arb_order_fifo
    import sram_req_arbiter_pkg::*;
#(
    parameter int OT_DEPTH = ARB_OT_DEPTH
) (
    input  logic    clk,
    input  logic    resetn,
    input  logic    push,
    input  logic    pop,
    input  arb_id_t id_in,
    output arb_id_t head_id,
    output logic    full,
    output logic    empty
);
    localparam int PW = $clog2(OT_DEPTH);

    logic [OT_DEPTH-1:0] ids;
    logic [PW-1:0]       wptr, rptr;
    logic [PW:0]         count;
    logic                do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = count == (PW+1)'(OT_DEPTH);
    assign empty   = count == '0;
    assign head_id = ids[rptr];

    // Pointers wrap naturally because OT_DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ids   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                ids[wptr] <= id_in;
                wptr      <= wptr + PW'(1);
            end
            if (do_pop) rptr <= rptr + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like port between inst (id 0) and data (id 1) requesters.
// Define ARB_DATA_PRIORITY_EN for fixed data-over-inst priority on ties; otherwise round-robin.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int OT_DEPTH = ARB_OT_DEPTH
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    logic    lock, lock_hold, full, empty, hs, pop;
    arb_id_t lock_id, grant, tie_id, head_id;

`ifdef ARB_DATA_PRIORITY_EN
    assign tie_id = ARB_ID_DATA;
`else
    arb_id_t last_id;

    assign tie_id = ~last_id;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) last_id <= ARB_ID_DATA;
        else if (hs) last_id <= grant;
    end
`endif

    // A pending lock only holds while its owner keeps requesting.
    assign lock_hold = lock & (lock_id == ARB_ID_DATA ? data_req : inst_req);
    assign grant     = lock_hold ? lock_id :
                       (inst_req & data_req) ? tie_id :
                       data_req ? ARB_ID_DATA : ARB_ID_INST;

    assign mem_req      = (inst_req | data_req) & ~full & resetn;
    assign hs           = mem_req & mem_addr_ok;
    assign inst_addr_ok = hs & (grant == ARB_ID_INST);
    assign data_addr_ok = hs & (grant == ARB_ID_DATA);

    assign mem_wr    = grant == ARB_ID_DATA ? data_wr    : inst_wr;
    assign mem_size  = grant == ARB_ID_DATA ? data_size  : inst_size;
    assign mem_wstrb = grant == ARB_ID_DATA ? data_wstrb : inst_wstrb;
    assign mem_addr  = grant == ARB_ID_DATA ? data_addr  : inst_addr;
    assign mem_wdata = grant == ARB_ID_DATA ? data_wdata : inst_wdata;

    assign pop          = mem_data_ok & ~empty & resetn;
    assign inst_data_ok = pop & (head_id == ARB_ID_INST);
    assign data_data_ok = pop & (head_id == ARB_ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock    <= 1'b0;
            lock_id <= ARB_ID_INST;
        end else begin
            lock    <= mem_req & ~mem_addr_ok;
            lock_id <= grant;
        end
    end

    arb_order_fifo #(.OT_DEPTH(OT_DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (hs),
        .pop     (pop),
        .id_in   (grant),
        .head_id (head_id),
        .full    (full),
        .empty   (empty)
    );
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: directed self-checking bench for sram_req_arbiter (default depth 4).
module tb_sram_req_arbiter;
`ifdef ARB_DATA_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif
    localparam logic [31:0] IA = 32'h0000_1000;
    localparam logic [31:0] DA = 32'h0000_2000;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 1;
    logic [1:0]  inst_size = 2'd2, data_size = 2'd1;
    logic [3:0]  inst_wstrb = 4'hf, data_wstrb = 4'h3;
    logic [31:0] inst_addr = IA, inst_wdata = 32'h1111_1111;
    logic [31:0] data_addr = DA, data_wdata = 32'h2222_2222;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok = 0, mem_data_ok = 0;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0;
    int          checks = 0, failures = 0;
    logic [3:0]  g32, g34;

    always #5 clk = ~clk;

    sram_req_arbiter dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set(input logic ir, input logic dr, input logic aok, input logic dok);
        inst_req = ir; data_req = dr; mem_addr_ok = aok; mem_data_ok = dok;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        g32 = PRIO ? 4'b1111 : 4'b1010;
        g34 = 4'b0110;
        // outputs forced low while reset is held
        set(1, 0, 1, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_inst_addr_ok", inst_addr_ok, 0);
        check("rst_inst_data_ok", inst_data_ok, 0);
        tick; tick;
        resetn = 1'b1;
        // single inst read
        inst_addr = 32'h1FC0_0000;
        set(1, 0, 1, 0);
        check("r31_mem_req", mem_req, 1);
        check("r31_inst_addr_ok", inst_addr_ok, 1);
        check("r31_data_addr_ok", data_addr_ok, 0);
        check("r31_mem_addr", mem_addr, 32'h1FC0_0000);
        check("r31_mem_size", mem_size, 2'd2);
        tick;
        mem_rdata = 32'h2408_0001;
        set(0, 0, 0, 1);
        check("r31_inst_data_ok", inst_data_ok, 1);
        check("r31_data_data_ok", data_data_ok, 0);
        check("r31_inst_rdata", inst_rdata, 32'h2408_0001);
        check("r31_data_rdata", data_rdata, 32'h2408_0001);
        tick;
        inst_addr = IA;
        resetn = 1'b0; #1; resetn = 1'b1; #1;
        // back-to-back ties fill the FIFO
        for (int i = 0; i < 4; i++) begin
            set(1, 1, 1, 0);
            check("r32_inst_addr_ok", inst_addr_ok, !g32[i]);
            check("r32_data_addr_ok", data_addr_ok, g32[i]);
            check("r32_mem_addr", mem_addr, g32[i] ? DA : IA);
            check("r32_mem_wr", mem_wr, g32[i]);
            tick;
        end
        set(1, 1, 1, 0);
        check("r32_full_mem_req", mem_req, 0);
        check("r32_full_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        for (int i = 0; i < 4; i++) begin
            set(0, 0, 0, 1);
            check("r32_inst_data_ok", inst_data_ok, !g32[i]);
            check("r32_data_data_ok", data_data_ok, g32[i]);
            tick;
        end
        // grant lock survives a rising data_req
        set(1, 0, 1, 0);
        check("r33_pre_inst_addr_ok", inst_addr_ok, 1);
        tick;
        set(1, 0, 0, 1);
        check("r33_pop_inst_data_ok", inst_data_ok, 1);
        check("r33_wait_inst_addr_ok", inst_addr_ok, 0);
        tick;
        for (int i = 0; i < 3; i++) begin
            set(1, 1, 0, 0);
            check("r33_lock_mem_addr", mem_addr, IA);
            check("r33_lock_data_addr_ok", data_addr_ok, 0);
            tick;
        end
        set(1, 1, 1, 0);
        check("r33_acc_inst_addr_ok", inst_addr_ok, 1);
        check("r33_acc_data_addr_ok", data_addr_ok, 0);
        tick;
        set(0, 1, 1, 1);
        check("r33_data_addr_ok", data_addr_ok, 1);
        check("r33_inst_data_ok", inst_data_ok, 1);
        tick;
        set(0, 0, 0, 1);
        check("r33_data_data_ok", data_data_ok, 1);
        tick;
        // locked owner drops its request
        set(1, 0, 0, 0);
        tick;
        set(0, 1, 0, 0);
        check("drop_mem_addr", mem_addr, DA);
        check("drop_mem_req", mem_req, 1);
        tick;
        set(0, 1, 1, 0);
        check("drop_data_addr_ok", data_addr_ok, 1);
        tick;
        set(0, 0, 0, 1);
        check("drop_data_data_ok", data_data_ok, 1);
        tick;
        // ordered responses for inst, data, data, inst
        for (int i = 0; i < 4; i++) begin
            set(!g34[i], g34[i], 1, 0);
            check("r34_addr_ok", {inst_addr_ok, data_addr_ok}, g34[i] ? 2'b01 : 2'b10);
            tick;
        end
        set(1, 1, 1, 0);
        check("r34_full_mem_req", mem_req, 0);
        set(1, 1, 1, 1);
        check("r35_full_pop_mem_req", mem_req, 0);
        check("r35_full_pop_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        check("r35_full_pop_inst_data_ok", inst_data_ok, 1);
        tick;
        for (int i = 1; i < 4; i++) begin
            set(0, 0, 0, 1);
            check("r34_inst_data_ok", inst_data_ok, !g34[i]);
            check("r34_data_data_ok", data_data_ok, g34[i]);
            tick;
        end
        set(0, 0, 0, 1);
        check("r35_spurious", {inst_data_ok, data_data_ok}, 0);
        tick;
        set(1, 0, 1, 0);
        tick;
        set(0, 0, 0, 1);
        check("r35_after_inst_data_ok", inst_data_ok, 1);
        check("r35_after_data_data_ok", data_data_ok, 0);
        tick;
        // reset with two outstanding
        set(0, 1, 1, 0);
        tick;
        set(1, 0, 1, 0);
        tick;
        set(1, 1, 1, 1);
        resetn = 1'b0;
        #1;
        check("r36_mem_req", mem_req, 0);
        check("r36_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        check("r36_data_ok", {inst_data_ok, data_data_ok}, 0);
        tick;
        set(0, 0, 0, 0);
        resetn = 1'b1;
        set(0, 0, 0, 1);
        check("r36_late_data_ok", {inst_data_ok, data_data_ok}, 0);
        tick;
        set(1, 1, 1, 0);
        check("r36_first_tie", {inst_addr_ok, data_addr_ok}, PRIO ? 2'b01 : 2'b10);
        tick;
        set(0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_req_arbiter.md
SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 Parameter OT_DEPTH, default 4, maximum outstanding accepted-but-unanswered requests; power of 2, range 2..8.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 resetn  in  1  reset; asynchronous, active-low.
REQ-004 inst_req, inst_wr  in  1 each  instruction-side request valid and write flag.
REQ-005 inst_size  in  2; inst_wstrb  in  4; inst_addr, inst_wdata  in  32 each  instruction-side request payload.
REQ-006 inst_addr_ok, inst_data_ok  out  1 each; inst_rdata  out  32  instruction-side responses.
REQ-007 data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data-side request; same meaning as inst_*.
REQ-008 data_addr_ok, data_data_ok  out  1 each; data_rdata  out  32  data-side responses.
REQ-009 mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/4/32/32  shared downstream SRAM-like request.
REQ-010 mem_addr_ok, mem_data_ok  in  1 each; mem_rdata  in  32  shared downstream responses.

Function
REQ-011 Arbiter SHALL share one SRAM-like port between two requesters: id 0 = inst, id 1 = data.
REQ-012 Request selection SHALL be combinational; winner's payload driven on mem_*; loser's *_addr_ok = 0.
REQ-013 mem_req SHALL = (inst_req | data_req) & ~full & ~reset_active; full = (outstanding count == OT_DEPTH).
REQ-014 Address handshake completes when mem_req & mem_addr_ok; winner's *_addr_ok = mem_addr_ok & mem_req & grant, same cycle.
REQ-015 Grant lock: if mem_req=1 and mem_addr_ok=0, the registered grant SHALL be held next cycle, even if the other requester rises (no payload switch mid-request).
REQ-016 Lock SHALL clear on handshake; if the locked requester drops req, lock clears and arbitration re-runs same cycle.
REQ-017 Tie (both req, no lock): round-robin; requester not granted at last handshake wins.
REQ-018 On each handshake the winner id SHALL be pushed into an in-order ID FIFO of depth OT_DEPTH.
REQ-019 mem_data_ok SHALL pop the FIFO head; head id 0 -> inst_data_ok = 1, id 1 -> data_data_ok = 1, same cycle (zero latency); other *_data_ok = 0.
REQ-020 mem_rdata SHALL be broadcast to inst_rdata and data_rdata unregistered.
REQ-021 Simultaneous push and pop: count unchanged, both pointers advance; full SHALL block mem_req even if a pop occurs in the same cycle.
REQ-022 mem_data_ok while FIFO empty SHALL be ignored: no *_data_ok, count stays 0.
REQ-023 Count and pointers SHALL wrap modulo OT_DEPTH; count width clog2(OT_DEPTH)+1.
REQ-024 Read and write transactions share the ordering; write responses are routed identically.

Reset
REQ-025 On resetn=0, asynchronously: FIFO empty, count 0, lock cleared, round-robin last-winner = data (inst wins first tie).
REQ-026 During reset all outputs SHALL be 0: mem_req, *_addr_ok, *_data_ok.
REQ-027 Reset mid-transaction drops all outstanding ids; late mem_data_ok after reset falls under REQ-022.

Configuration
REQ-028 Macro ARB_DATA_PRIORITY_EN: defined -> fixed priority, data beats inst on tie (REQ-017 replaced; lock REQ-015 still applies); undefined -> round-robin.

Structure
REQ-029 Shared package SHALL hold ARB_ID_INST=0, ARB_ID_DATA=1 and the default OT_DEPTH constant.
REQ-030 ID FIFO SHALL be a sub-module arb_order_fifo: push/pop/id_in/head_id/full/empty, OT_DEPTH parameter.

Verification
REQ-031 inst_req only, addr 0x1FC00000, mem_addr_ok=1 -> inst_addr_ok=1 same cycle, mem_addr=0x1FC00000; mem_data_ok with rdata 0x24080001 -> inst_data_ok=1, inst_rdata=0x24080001.
REQ-032 Both req every cycle, mem_addr_ok=1 -> grants alternate inst, data, inst, data; with ARB_DATA_PRIORITY_EN -> data every cycle.
REQ-033 inst granted with mem_addr_ok=0 for 3 cycles while data_req rises -> mem_addr stays the inst address until accepted.
REQ-034 4 handshakes (inst, data, data, inst) with no data_ok -> mem_req=0 on 5th; then 4 data_ok -> routed inst, data, data, inst in order.
REQ-035 Full FIFO plus same-cycle mem_data_ok -> no push that cycle, count 4->3; spurious mem_data_ok when empty -> no *_data_ok.
REQ-036 resetn low with 2 outstanding -> outputs 0 immediately; after release count 0 and first tie won by inst.
